// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  // STATUS register bit positions
  localparam int ST_FULL   = 0;
  localparam int ST_BUSY   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_PARITY = 4;

endpackage

// File: rtl/tx_fifo.sv
// Circular TX byte FIFO: read/write pointers plus an occupancy count.
// The caller never pushes when full unless it pops in the same cycle,
// and never pops when empty.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  // Pointer and occupancy tracking; power-of-two depth gives free wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the core data port.
// TXDATA at BASE_ADDR, STATUS at BASE_ADDR+4.
// Build option: define UART_PARITY_EN to add an even-parity bit to each frame.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low) for one bit time
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (UART_PARITY_EN builds only)
// STOP   | stop bit (high); may chain straight into the next START
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h100,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        Sel,
  output logic [31:0] ReadData,
  output logic        tx
);

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_TC = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          pop;
  logic          push;
  logic          wr_tx, wr_st;
  logic          ovf_set, ovf_clr;
  logic          overflow;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [31:0]   status;
  logic          unused_bits;
`ifdef UART_PARITY_EN
  logic          par, par_n;
`endif

  // Address bits [1:0] and the upper store bytes carry no meaning here.
  assign unused_bits = ^{WriteData[31:8], DataAdr[1:0]};

  assign Sel     = (DataAdr[31:3] == BASE_ADDR[31:3]);
  assign wr_tx   = MemWrite & Sel & ~DataAdr[2];
  assign wr_st   = MemWrite & Sel &  DataAdr[2];
  assign push    = wr_tx & (~fifo_full | pop);
  assign ovf_set = wr_tx & fifo_full & ~pop;
  assign ovf_clr = wr_st & WriteData[3];

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Status word and register read mux; TXDATA and unselected reads give 0.
  always_comb begin
    status            = '0;
    status[ST_FULL]   = fifo_full;
    status[ST_BUSY]   = (state != IDLE);
    status[ST_EMPTY]  = fifo_empty;
    status[ST_OVF]    = overflow;
`ifdef UART_PARITY_EN
    status[ST_PARITY] = 1'b1;
`endif
    ReadData = (Sel && DataAdr[2]) ? status : '0;
  end

  // Next-state, bit timing and line value; cnt is a down-counter per bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    tx_n    = 1'b1;
    pop     = 1'b0;
`ifdef UART_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      START: begin
        tx_n = 1'b0;
        if (cnt == '0) begin
          state_n = DATA;
          cnt_n   = CNT_TC;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (cnt == '0) begin
          cnt_n   = CNT_TC;
          shift_n = shift >> 1;
          if (idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx_n = par;
        if (cnt == '0) begin
          state_n = STOP;
          cnt_n   = CNT_TC;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (cnt == '0) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A pop always starts a fresh frame, from IDLE or straight out of STOP.
    if (pop) begin
      state_n = START;
      cnt_n   = CNT_TC;
      idx_n   = '0;
      shift_n = fifo_dout;
`ifdef UART_PARITY_EN
      par_n   = ^fifo_dout;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Serializer datapath and registered (glitch-free) line output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

`ifdef UART_PARITY_EN
  // Parity of the byte in flight, captured when it is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par <= 1'b0;
    else       par <= par_n;
  end
`endif

  // Sticky overflow flag; a new overflow beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (honours UART_PARITY_EN).
module tb_mmio_uart_tx;

  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h100;
`ifdef UART_PARITY_EN
  localparam int   NBITS = 11;
  localparam logic PAR   = 1'b1;
`else
  localparam int   NBITS = 10;
  localparam logic PAR   = 1'b0;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        Sel;
  logic [31:0] ReadData;
  logic        tx;

  int checks = 0;
  int failures = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .Sel       (Sel),
    .ReadData  (ReadData),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (queue + frame timeline) -------------
  logic [7:0] mq[$];
  int         cyc = 0;
  int         free_at = 0;
  int         cur_p = 0;
  logic [7:0] cur_b = '0;
  bit         cur_valid = 0;
  bit         m_ovf = 0;
  int         accepted = 0;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd8);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      free_at   = 0;
      cur_valid = 0;
      m_ovf     = 0;
    end else begin
      cyc = cyc + 1;
      if (mq.size() > 0 && cyc >= free_at) begin
        cur_b     = mq.pop_front();
        cur_p     = cyc;
        cur_valid = 1;
        free_at   = cyc + FRAME;
      end
      if (MemWrite && in_win(DataAdr)) begin
        if (DataAdr - BASE < 32'd4) begin
          if (mq.size() < DEPTH) begin
            mq.push_back(WriteData[7:0]);
            accepted = accepted + 1;
          end else begin
            m_ovf = 1;
          end
        end else if (WriteData[3]) begin
          m_ovf = 0;
        end
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!cur_valid || cyc < cur_p + 1) return 1'b1;
    k = (cyc - cur_p - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur_b[k-1];
    if (NBITS == 11 && k == 9) return ^cur_b;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    return {27'b0, PAR, m_ovf, (mq.size() == 0), (cyc < free_at), (mq.size() == DEPTH)};
  endfunction

  // Cycle-exact line check against the model timeline.
  always @(negedge clk) begin
    checks++;
    assert (tx === exp_tx()) else begin
      failures++;
      $error("FAIL tx_line cyc=%0d observed=%b expected=%b", cyc, tx, exp_tx());
    end
  end

  // Minimal frame counter: a low level outside a frame window is a start bit.
  int rx_frames = 0;
  int rx_left = 0;
  always @(negedge clk or posedge reset) begin
    if (reset) rx_left = 0;
    else if (rx_left > 0) rx_left = rx_left - 1;
    else if (tx == 1'b0) begin
      rx_frames = rx_frames + 1;
      rx_left   = FRAME - 1;
    end
  end

  // ---------------- helpers -----------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic [3:0] low);
    DataAdr = BASE + 32'd4;
    #1;
    chk({tag, "_const"}, ReadData, {27'b0, PAR, low});
    chk({tag, "_model"}, ReadData, exp_status());
  endtask

  task automatic chk_busy(input string tag, input logic b);
    DataAdr = BASE + 32'd4;
    #1;
    chk(tag, {31'b0, ReadData[1]}, {31'b0, b});
    chk({tag, "_model"}, ReadData, exp_status());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed and random sequence ---------------------------
  initial begin
    int f0;
    int a0;
    logic [31:0] addr;

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    step();

    // Idle decode after reset
    chk("tx_reset", {31'b0, tx}, 32'd1);
    chk_status("status_idle", 4'b0100);
    chk("sel_104", {31'b0, Sel}, 32'd1);
    DataAdr = BASE; #1;
    chk("sel_100", {31'b0, Sel}, 32'd1);
    chk("rd_txdata", ReadData, 32'd0);
    DataAdr = 32'h54; #1;
    chk("sel_54", {31'b0, Sel}, 32'd0);
    chk("rd_54", ReadData, 32'd0);
    f0 = rx_frames;
    store(32'h54, 32'hA5);
    step();
    chk_status("status_after_dmem", 4'b0100);

    // Single frame 0x47
    store(BASE, 32'h47);                 // push edge N
    step();  chk("t47_n1_idle", {31'b0, tx}, 32'd1);
    step();  chk("t47_start", {31'b0, tx}, 32'd0);
    repeat (16) step(); chk("t47_bit0", {31'b0, tx}, 32'd1);
    repeat (48) step(); chk("t47_bit3", {31'b0, tx}, 32'd0);
    repeat (80) step(); chk("t47_bit9", {31'b0, tx}, {31'b0, ~PAR});
    repeat (FRAME - 146) step(); chk_busy("t47_busy_last", 1'b1);
    step(); chk_busy("t47_idle_after", 1'b0);
    chk("t47_frames", rx_frames - f0, 32'd1);

`ifdef UART_PARITY_EN
    // Parity frame 0x07: odd number of ones, so the parity bit is 1
    store(BASE, 32'h07);
    repeat (146) step(); chk("par07_bit", {31'b0, tx}, 32'd1);
    repeat (16) step();  chk("par07_stop", {31'b0, tx}, 32'd1);
    repeat (FRAME - 162) step(); chk_busy("par07_busy_last", 1'b1);
    step(); chk_busy("par07_idle_after", 1'b0);
`endif

    // Back-to-back 0x55, 0xAA
    f0 = rx_frames;
    store(BASE, 32'h55);                 // edge N
    store(BASE, 32'hAA);                 // edge N+1
    repeat (FRAME - 1) step(); chk("b2b_stop1", {31'b0, tx}, 32'd1);
    step(); chk("b2b_gap", {31'b0, tx}, 32'd1);
    step(); chk("b2b_start2", {31'b0, tx}, 32'd0);
    repeat (FRAME - 2) step(); chk_busy("b2b_busy_last", 1'b1);
    step(); chk_busy("b2b_idle_after", 1'b0);
    chk("b2b_frames", rx_frames - f0, 32'd2);

    // Overflow burst: 6 stores, one pop during the burst, 6th dropped
    f0 = rx_frames;
    for (int i = 0; i < 6; i++) store(BASE, 32'h10 + i);
    chk_status("burst_status", 4'b1011);
    store(BASE + 32'd4, 32'h8);
    chk_status("burst_clear", 4'b0011);
    repeat (5 * FRAME + 10) step();
    chk("burst_frames", rx_frames - f0, 32'd5);
    chk_status("burst_done", 4'b0100);

    // Randomized traffic against the model
    f0 = rx_frames;
    a0 = accepted;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: addr = BASE + $urandom_range(0, 3);
        3, 4:    addr = BASE + 32'd4 + $urandom_range(0, 3);
        5:       addr = BASE + 32'd8;
        6:       addr = BASE - 32'd4;
        7:       addr = 32'h54;
        default: addr = $urandom;
      endcase
      DataAdr   = addr;
      WriteData = $urandom;
      MemWrite  = ($urandom_range(0, 11) == 0);
      #1;
      chk("rand_sel", {31'b0, Sel}, {31'b0, in_win(addr)});
      chk("rand_rd", ReadData, (in_win(addr) && (addr - BASE >= 32'd4)) ? exp_status() : 32'd0);
      step();
    end
    MemWrite = 1'b0;
    repeat (DEPTH * FRAME + FRAME + 10) step();
    chk("rand_frames", rx_frames - f0, accepted - a0);
    chk_status("rand_drained", {m_ovf, 3'b100});

    // Reset in the middle of a frame
    store(BASE, 32'h00);
    repeat (41) step();
    chk("rst_pre_tx", {31'b0, tx}, 32'd0);
    #2 reset = 1'b1;
    #1 chk("rst_tx_async", {31'b0, tx}, 32'd1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    step();
    chk_status("rst_status", 4'b0100);
    f0 = rx_frames;
    store(BASE, 32'h3C);
    repeat (FRAME + 2) step();
    chk("rst_after_frames", rx_frames - f0, 32'd1);
    chk_status("rst_after_idle", 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
